udp_tx_frame_buffer: RTL
========================

Name: udp_tx_frame_buffer

Overview:
Store-and-forward byte buffer that sits directly upstream of the UDP stack send port. It accepts user payload bytes with arbitrary gaps and a user-side ready. It replays each complete frame as one gap-free burst, with the byte count valid from the first beat, because the stack needs the length up front and has no mid-frame backpressure. Oversized frames and frames that do not fit are dropped whole.

Parameters:
P_DEPTH, 2048, data RAM depth in bytes (power of two).
P_LEN_DEPTH, 8, number of committed frames the length FIFO can hold (power of two).
P_MAX_LEN, 1472, largest accepted payload in bytes.
P_IFG, 12, minimum idle cycles between output frames.

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous reset, active-low
i_user_data  in  8  payload byte
i_user_valid  in  1  byte qualifier
i_user_last  in  1  final byte of frame
o_user_ready  out  1  byte accepted when valid&ready
o_send_udp_data  out  8  to stack i_send_udp_data
o_send_udp_len  out  16  to stack i_send_udp_len
o_send_udp_last  out  1  to stack i_send_udp_last
o_send_udp_valid  out  1  to stack i_send_udp_valid
i_send_ready  in  1  from stack o_send_ready; sampled only before frame start
o_drop  out  1  one-cycle pulse: frame discarded
o_frame_cnt  out  4  committed frames waiting (saturates at 15)

Behaviour:
- Reset (i_rst=0, async): all outputs 0. Pointers, counters and FIFOs are cleared. Partial or committed frames are lost. Output state returns to IDLE.
- Clock and reset are fixed as stated above: one clock, asynchronous active-low reset.
- o_user_ready = !len_fifo_full.
- Write side:
  - Per-frame byte counter wr_cnt (16b). Frame start pointer fs_ptr. Write pointer wr_ptr is ADDR_W+1 bits, where ADDR_W = log2(P_DEPTH).
  - Each accepted byte is written at wr_ptr, then wr_ptr++ and wr_cnt++.
- Commit: on an accepted byte with i_user_last=1 and no drop pending:
  - push wr_cnt+1 into the length FIFO;
  - fs_ptr <= wr_ptr+1; wr_cnt <= 0.
  - A 1-byte frame (last on the first byte) is legal, with len=1.
- Drop:
  - Triggers: an accepted byte would make wr_cnt+1 > P_MAX_LEN, or (wr_ptr - rd_commit_ptr) == P_DEPTH (buffer full).
  - Action: enter DROP. Further bytes are accepted and discarded until i_user_last. On that byte: wr_ptr <= fs_ptr, wr_cnt <= 0, o_drop=1 for 1 cycle. Nothing is pushed.
  - If the trigger byte itself carries last, the restore and pulse happen in that same cycle.
- Read FSM:
  - IDLE: when len_fifo non-empty & i_send_ready=1, pop length into len_reg and go to FETCH.
  - FETCH: present RAM read address rd_ptr (1-cycle RAM latency), then go to SEND.
  - SEND: o_send_udp_valid=1 for exactly len_reg consecutive cycles.
    - o_send_udp_len = len_reg, held stable throughout the frame and 0 otherwise.
    - o_send_udp_last=1 on the final beat only.
    - rd_ptr advances each beat.
    - On the last beat rd_commit_ptr <= rd_ptr+1, freeing the space. Then go to GAP.
  - GAP: count P_IFG cycles with valid=0, then return to IDLE.
  - i_send_ready is ignored once the FSM leaves IDLE.
- Latency:
  - Last byte accepted at edge k, FIFO empty, output in IDLE, i_send_ready=1 → first o_send_udp_valid in the cycle after edge k+3.
  - If i_send_ready=0, the frame waits indefinitely.
- Simultaneous commit and pop in the same cycle: FIFO count unchanged. o_frame_cnt stays correct.
- Simultaneous byte write and read at different addresses is legal. A write to an uncommitted address can never alias unread data because of the full check.
- Pointer wrap: modulo 2^(ADDR_W+1). Full/empty is decided by the MSB-differs compare.
- Outputs are registered; no combinational path from i_send_ready to the data outputs.

Decomposition:
- Shared package: ADDR_W derivation, FSM state encoding (IDLE, FETCH, SEND, GAP), default constants.
- One natural sub-module: sync_fifo_len (width 16, depth P_LEN_DEPTH, registered full/empty/count).
- The data RAM is an inferred simple dual-port array inside the top.

Test Plan:
1. Single frame: 18 bytes 0x00..0x11, gap-free, i_send_ready=1 → 3 cycles after the last write, 18 contiguous valid beats; len=18 on all beats; data 0x00..0x11; last on 0x11; then ≥12 idle cycles.
2. Backpressure: i_send_ready=0 and 3 frames of lengths 1, 5, 100 written → o_frame_cnt=3 and no output. Raise ready → three bursts of 1, 5 and 100 beats, each separated by ≥12 idle cycles; o_frame_cnt ends at 0.
3. Oversize: 1473-byte frame, then a 10-byte frame → o_drop pulses once on byte 1473; only the 10-byte frame is emitted, with len=10.
4. Buffer full: P_DEPTH=2048, ready=0, two 1000-byte frames, then a 100-byte frame → third frame dropped with o_drop. Set ready=1, send a 100-byte frame afterwards → frames of 1000, 1000 and 100 appear.
5. Length FIFO full: 8 committed 1-byte frames with ready=0 → o_user_ready=0. Pop one frame → o_user_ready=1 the next cycle.
6. Reset mid-SEND: assert i_rst=0 during beat 7 of a 50-byte frame → all outputs 0 immediately and o_frame_cnt=0. A 4-byte frame written after release is emitted intact.

Source files
------------

// File: rtl/udp_tx_frame_buffer_pkg.sv
// rtl/udp_tx_frame_buffer_pkg.sv - shared constants, read FSM encoding and address-width helper
package udp_tx_frame_buffer_pkg;

   localparam int DEF_DEPTH     = 2048;
   localparam int DEF_LEN_DEPTH = 8;
   localparam int DEF_MAX_LEN   = 1472;
   localparam int DEF_IFG       = 12;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_SEND  = 2'd2,
      ST_GAP   = 2'd3
   } rd_state_t;

   function automatic int addr_w(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/udp_tx_frame_buffer_if.sv
// rtl/udp_tx_frame_buffer_if.sv - user write port and stack send port bundle
interface udp_tx_frame_buffer_if;

   logic [7:0]  user_data;
   logic        user_valid;
   logic        user_last;
   logic        user_ready;
   logic [7:0]  send_udp_data;
   logic [15:0] send_udp_len;
   logic        send_udp_last;
   logic        send_udp_valid;
   logic        send_ready;
   logic        drop;
   logic [3:0]  frame_cnt;

   modport master (
      output user_data, user_valid, user_last, send_ready,
      input  user_ready, send_udp_data, send_udp_len, send_udp_last, send_udp_valid,
      input  drop, frame_cnt
   );

   modport slave (
      input  user_data, user_valid, user_last, send_ready,
      output user_ready, send_udp_data, send_udp_len, send_udp_last, send_udp_valid,
      output drop, frame_cnt
   );

endinterface

// File: rtl/udp_tx_frame_buffer_sync_fifo_len.sv
// rtl/udp_tx_frame_buffer_sync_fifo_len.sv - frame length FIFO with registered full/empty/count
module udp_tx_frame_buffer_sync_fifo_len
   import udp_tx_frame_buffer_pkg::*;
#(
   parameter int P_WIDTH = 16,
   parameter int P_DEPTH = DEF_LEN_DEPTH
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        push,
   input  logic [P_WIDTH-1:0]          din,
   input  logic                        pop,
   output logic [P_WIDTH-1:0]          dout,
   output logic                        full,
   output logic                        empty,
   output logic [addr_w(P_DEPTH):0]    count
);

   localparam int AW = addr_w(P_DEPTH);

   logic [P_WIDTH-1:0] mem [P_DEPTH];
   logic [AW-1:0]      wr_idx;
   logic [AW-1:0]      rd_idx;
   logic               do_push;
   logic               do_pop;
   logic [AW:0]        next_count;

   // a pop in the same cycle frees the slot, so a push into a full FIFO is allowed then
   assign do_push = push & (~full | pop);
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_idx];

   // occupancy after this cycle's push/pop
   always_comb begin
      next_count = count;
      case ({do_push, do_pop})
         2'b10:   next_count = count + 1'b1;
         2'b01:   next_count = count - 1'b1;
         default: next_count = count;
      endcase
   end

   // length storage
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_idx] <= din;
   end

   // pointers and registered status flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_idx <= '0;
         rd_idx <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push) wr_idx <= wr_idx + 1'b1;
         if (do_pop)  rd_idx <= rd_idx + 1'b1;
         count <= next_count;
         full  <= (32'(next_count) == P_DEPTH);
         empty <= (next_count == '0);
      end
   end

endmodule

// File: rtl/udp_tx_frame_buffer.sv
// rtl/udp_tx_frame_buffer.sv - store-and-forward frame buffer feeding the UDP send port
module udp_tx_frame_buffer
   import udp_tx_frame_buffer_pkg::*;
#(
   parameter int P_DEPTH     = DEF_DEPTH,
   parameter int P_LEN_DEPTH = DEF_LEN_DEPTH,
   parameter int P_MAX_LEN   = DEF_MAX_LEN,
   parameter int P_IFG       = DEF_IFG
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   udp_tx_frame_buffer_if.slave  bus
);

   localparam int ADDR_W = addr_w(P_DEPTH);
   localparam int LEN_AW = addr_w(P_LEN_DEPTH);

   logic [7:0]      mem [P_DEPTH];
   logic [7:0]      ram_q;
   logic [ADDR_W:0] wr_ptr;
   logic [ADDR_W:0] fs_ptr;
   logic [ADDR_W:0] rd_ptr;
   logic [ADDR_W:0] rd_commit_ptr;
   logic [15:0]     wr_cnt;
   logic            drop_pend;
   logic            drop_r;
   logic            run;
   logic            accept;
   logic            buf_full;
   logic            too_long;
   logic            trig;
   logic            wr_en;
   logic            rd_en;
   logic            fifo_push;
   logic            fifo_pop;
   logic            fifo_full;
   logic            fifo_empty;
   logic [15:0]     fifo_dout;
   logic [LEN_AW:0] fifo_count;
   rd_state_t       state;
   logic [15:0]     len_reg;
   logic [15:0]     beat_cnt;
   logic [15:0]     gap_cnt;
   logic [7:0]      send_data;
   logic [15:0]     send_len;
   logic            send_last;
   logic            send_valid;

   // run holds ready low while in reset so every output reads 0 there
   assign bus.user_ready = run & ~fifo_full;
   assign accept         = bus.user_valid & bus.user_ready;

   // MSB differs and low bits equal: the write side has lapped the committed read point
   assign buf_full  = (wr_ptr[ADDR_W] != rd_commit_ptr[ADDR_W]) &&
                      (wr_ptr[ADDR_W-1:0] == rd_commit_ptr[ADDR_W-1:0]);
   assign too_long  = (wr_cnt >= 16'(P_MAX_LEN));
   assign trig      = accept & ~drop_pend & (too_long | buf_full);
   assign wr_en     = accept & ~drop_pend & ~trig;
   assign fifo_push = wr_en & bus.user_last;
   assign fifo_pop  = (state == ST_IDLE) & ~fifo_empty & bus.send_ready;

   // one read per beat: FETCH primes ram_q, SEND reads ahead except on the final beat
   assign rd_en = (state == ST_FETCH) | ((state == ST_SEND) & (beat_cnt > 16'd1));

   assign bus.send_udp_data  = send_data;
   assign bus.send_udp_len   = send_len;
   assign bus.send_udp_last  = send_last;
   assign bus.send_udp_valid = send_valid;
   assign bus.drop           = drop_r;
   assign bus.frame_cnt      = (32'(fifo_count) > 15) ? 4'd15 : 4'(fifo_count);

   udp_tx_frame_buffer_sync_fifo_len #(
      .P_WIDTH (16),
      .P_DEPTH (P_LEN_DEPTH)
   ) u_len_fifo (
      .clk   (i_clk),
      .rst_n (i_rst),
      .push  (fifo_push),
      .din   (wr_cnt + 16'd1),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // simple dual-port data RAM with one-cycle read latency
   always_ff @(posedge i_clk) begin
      if (wr_en) mem[wr_ptr[ADDR_W-1:0]] <= bus.user_data;
      if (rd_en) ram_q <= mem[rd_ptr[ADDR_W-1:0]];
   end

   // write side: byte counting, commit, and whole-frame drop with pointer rewind
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         run       <= 1'b0;
         wr_ptr    <= '0;
         fs_ptr    <= '0;
         wr_cnt    <= '0;
         drop_pend <= 1'b0;
         drop_r    <= 1'b0;
      end else begin
         run    <= 1'b1;
         drop_r <= 1'b0;
         if (accept) begin
            if (drop_pend || trig) begin
               if (bus.user_last) begin
                  drop_pend <= 1'b0;
                  wr_ptr    <= fs_ptr;
                  wr_cnt    <= '0;
                  drop_r    <= 1'b1;
               end else begin
                  drop_pend <= 1'b1;
               end
            end else begin
               wr_ptr <= wr_ptr + 1'b1;
               if (bus.user_last) begin
                  fs_ptr <= wr_ptr + 1'b1;
                  wr_cnt <= '0;
               end else begin
                  wr_cnt <= wr_cnt + 16'd1;
               end
            end
         end
      end
   end

   // read FSM: pop a length, prime the RAM, burst the frame, then hold the inter-frame gap
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state         <= ST_IDLE;
         rd_ptr        <= '0;
         rd_commit_ptr <= '0;
         len_reg       <= '0;
         beat_cnt      <= '0;
         gap_cnt       <= '0;
         send_data     <= '0;
         send_len      <= '0;
         send_last     <= 1'b0;
         send_valid    <= 1'b0;
      end else begin
         send_data  <= '0;
         send_len   <= '0;
         send_last  <= 1'b0;
         send_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (fifo_pop) begin
                  len_reg  <= fifo_dout;
                  beat_cnt <= fifo_dout;
                  state    <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               rd_ptr <= rd_ptr + 1'b1;
               state  <= ST_SEND;
            end
            ST_SEND: begin
               send_valid <= 1'b1;
               send_data  <= ram_q;
               send_len   <= len_reg;
               send_last  <= (beat_cnt == 16'd1);
               if (beat_cnt == 16'd1) begin
                  rd_commit_ptr <= rd_ptr;
                  gap_cnt       <= '0;
                  state         <= ST_GAP;
               end else begin
                  rd_ptr   <= rd_ptr + 1'b1;
                  beat_cnt <= beat_cnt - 16'd1;
               end
            end
            ST_GAP: begin
               if (gap_cnt == 16'(P_IFG - 1)) state <= ST_IDLE;
               else gap_cnt <= gap_cnt + 16'd1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
